muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Multi-cycle sequencer for MULT/MULTU/DIV/DIVU and owner of the HI/LO register pair.
//  Sits beside the single-cycle ALU in EX: EX issues a one-cycle start, the block
//  iterates a radix-2 shift-add/shift-subtract datapath, and busy stalls the pipeline.
//  The block also services MTHI/MTLO writes and drives HI/LO to MFHI/MFLO.
// PARAMETERS
//  WIDTH   32   operand width; HI/LO are WIDTH each; iteration count = WIDTH
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous, active-low reset
//  start     in   1      issue pulse; sampled only in IDLE
//  op        in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//  A         in   WIDTH  rs operand (multiplicand / dividend)
//  B         in   WIDTH  rt operand (multiplier / divisor)
//  hi_we     in   1      MTHI write strobe
//  lo_we     in   1      MTLO write strobe
//  wdata     in   WIDTH  MTHI/MTLO data
//  flush     in   1      abort the in-flight operation (exception/branch kill)
//  busy      out  1      operation in flight; EX stall request
//  done      out  1      one-cycle pulse: HI/LO were updated on the previous edge
//  HI        out  WIDTH  HI register (product high / remainder)
//  LO        out  WIDTH  LO register (product low / quotient)
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, HI=0, LO=0, counter=0; async on rst_n low, any state.
//  FSM: IDLE -> CALC (start) ; CALC -> FIX (counter==WIDTH-1) ; FIX -> IDLE.
//   Any state -> IDLE on flush; flush wins over start in the same cycle.
//  IDLE: on start, latch |A|,|B| (signed ops) or raw A,B (unsigned ops), op, result signs;
//   counter cleared.
//  CALC: exactly WIDTH cycles, one bit per cycle; 2*WIDTH-bit accumulator.
//   Mul: add multiplicand if multiplier LSB=1, then shift right.
//   Div: restoring; shift left, trial-subtract, set quotient bit if non-negative.
//  FIX: negate as needed. Product sign = A^B for MULT. Quotient sign = A^B; remainder
//   sign = A (DIV). Write HI/LO on the FIX->IDLE edge; done=1 the following cycle only.
//  Latency: start sampled at edge E0; busy=1 for cycles after E0..E33 (33 cycles);
//   HI/LO/done valid after E33. done is never asserted together with busy.
//  start while busy: ignored (EX is stalled; no queueing).
//  Divide by zero: HI=A (unmodified dividend), LO={WIDTH{1'b1}}; full 33-cycle latency.
//  DIV overflow (A=0x8000_0000, B=0xFFFF_FFFF): LO=0x8000_0000, HI=0 (two's-complement wrap).
//  hi_we/lo_we in IDLE: write wdata on next edge.
//  hi_we/lo_we while busy: ignored.
//  hi_we/lo_we with start in the same cycle: write applies, start also accepted;
//   the result later overwrites both.
//  flush: HI/LO keep their pre-operation values, no done; busy=0 the cycle after flush.
//  Reset mid-operation: result discarded; HI/LO=0.
// TESTING
//  MULT A=0xFFFF_FFFE(-2) B=0x0000_0003 -> after 33 busy cycles HI=0xFFFF_FFFF LO=0xFFFF_FFFA, done 1 cycle.
//  MULTU A=0xFFFF_FFFF B=0xFFFF_FFFF -> HI=0xFFFF_FFFE LO=0x0000_0001.
//  DIV A=-7(0xFFFF_FFF9) B=2 -> LO=0xFFFF_FFFD(-3) HI=0xFFFF_FFFF(-1).
//  DIVU A=100 B=0 -> HI=100 LO=0xFFFF_FFFF.
//  DIV A=0x8000_0000 B=0xFFFF_FFFF -> LO=0x8000_0000 HI=0.
//  MTLO 0x1234 in IDLE -> LO=0x1234 next cycle.
//  MTLO while busy -> LO unchanged.
//  start+flush at cycle 10 of CALC -> busy=0 next cycle, HI/LO unchanged, no done.
//  rst_n low mid-CALC -> HI=LO=0, busy=0 immediately.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// ---------------------------------------------------------------------------
// muldiv_seq_if
// Bundle between the EX stage (master) and the multiply/divide sequencer
// (slave).
//   start      issue pulse, sampled only while the sequencer is idle
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   A, B       rs / rt operands
//   hi_we      MTHI write strobe
//   lo_we      MTLO write strobe
//   wdata      MTHI/MTLO data
//   flush      abort the in-flight operation
//   busy       operation in flight (pipeline stall request)
//   done       one-cycle pulse after HI/LO take a new result
//   HI, LO     architectural HI/LO registers
// ---------------------------------------------------------------------------
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, op, A, B, hi_we, lo_we, wdata, flush,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, op, A, B, hi_we, lo_we, wdata, flush,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer and owner of HI/LO.
// Radix-2 datapath: one bit per cycle for WIDTH cycles, then a single fix-up
// cycle that applies signs and writes HI/LO.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    muldiv_seq_if slave modport (start/op/A/B/hi_we/lo_we/wdata/flush
//          in; busy/done/HI/LO out)
// ---------------------------------------------------------------------------
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic               is_div_q, is_div_d;
  logic               q_neg_q, q_neg_d; // product / quotient sign
  logic               r_neg_q, r_neg_d; // remainder sign (follows dividend)
  logic               dz_q, dz_d;       // divide by zero
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  // Operand magnitudes at issue
  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  always_comb begin
    signed_op = ~bus.op[0];
    a_neg     = signed_op & bus.A[WIDTH-1];
    b_neg     = signed_op & bus.B[WIDTH-1];
    a_abs     = a_neg ? (~bus.A + 1'b1) : bus.A;
    b_abs     = b_neg ? (~bus.B + 1'b1) : bus.B;
  end

  // One multiply step: conditional add into the upper half, then shift the
  // whole accumulator right with the carry entering at the top.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  // One restoring divide step: shift left, trial-subtract the divisor from
  // the (WIDTH+1)-bit shifted remainder, keep it only if non-negative.
  logic [WIDTH:0]     rem_sh, trial;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    trial    = rem_sh - {1'b0, opnd_q};
    div_next = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                            : {trial[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
  end

  // Sign fix-up. Divide by zero leaves the remainder equal to the dividend
  // magnitude, which the remainder sign turns back into the original A;
  // only the quotient needs forcing to all ones.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, res_hi, res_lo;

  always_comb begin
    prod_fix = q_neg_q ? (~acc_q + 1'b1) : acc_q;
    rem_fix  = r_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    if (dz_q)
      quot_fix = {WIDTH{1'b1}};
    else
      quot_fix = q_neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    res_hi = is_div_q ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
    res_lo = is_div_q ? quot_fix : prod_fix[WIDTH-1:0];
  end

  // Next-state and register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.start && !bus.flush) begin
          state_d  = CALC;
          cnt_d    = '0;
          is_div_d = bus.op[1];
          acc_d    = {{WIDTH{1'b0}}, (bus.op[1] ? a_abs : b_abs)};
          opnd_d   = bus.op[1] ? b_abs : a_abs;
          q_neg_d  = a_neg ^ b_neg;
          r_neg_d  = a_neg;
          dz_d     = bus.op[1] & (bus.B == '0);
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.flush) begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.flush && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq
// Directed vectors against muldiv_seq. A behavioural model (plain 64-bit
// arithmetic plus a 33-cycle busy window) is compared with the DUT on every
// falling edge; the directed tasks also pin literal expected values.
// ---------------------------------------------------------------------------
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  muldiv_seq_if #(.WIDTH(32)) bus ();

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result {HI, LO} from the instruction definitions
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Model: idle, or busy for 33 cycles after the accepting edge
  logic        m_busy, m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_cnt  <= 0;
      m_res  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (bus.flush) m_busy <= 1'b0;
        else if (m_cnt == 32) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_hi   <= m_res[63:32];
          m_lo   <= m_res[31:0];
        end else m_cnt <= m_cnt + 1;
      end else begin
        if (bus.hi_we) m_hi <= bus.wdata;
        if (bus.lo_we) m_lo <= bus.wdata;
        if (bus.start && !bus.flush) begin
          m_busy <= 1'b1;
          m_cnt  <= 0;
          m_res  <= ref_result(bus.op, bus.A, bus.B);
        end
      end
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model busy", {31'b0, bus.busy}, {31'b0, m_busy});
      chk("model done", {31'b0, bus.done}, {31'b0, m_done});
      chk("model HI", bus.HI, m_hi);
      chk("model LO", bus.LO, m_lo);
      if (bus.busy && bus.done) chk("done with busy", 32'd1, 32'd0);
    end
  end

  // Issue leaves the bench at the falling edge after the accepting edge
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.A = a;
    bus.B = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
  endtask

  task automatic finish_op(input string name, input int exp_n,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({name, " busy cycles"}, 32'(n), 32'(exp_n));
    chk({name, " done"}, {31'b0, bus.done}, 32'd1);
    chk({name, " HI"}, bus.HI, exp_hi);
    chk({name, " LO"}, bus.LO, exp_lo);
    $display("%-8s HI=%h LO=%h busy_cycles=%0d", name, bus.HI, bus.LO, n);
    @(negedge clk);
    chk({name, " done pulse"}, {31'b0, bus.done}, 32'd0);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(op, a, b);
    finish_op(name, 33, exp_hi, exp_lo);
  endtask

  initial begin
    bit saw_done;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'b0, bus.busy}, 32'd0);
    chk("reset done", {31'b0, bus.done}, 32'd0);
    chk("reset HI", bus.HI, 32'd0);
    chk("reset LO", bus.LO, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // MTLO / MTHI in idle
    @(negedge clk);
    bus.lo_we = 1'b1; bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.lo_we = 1'b0;
    chk("mtlo idle", bus.LO, 32'h0000_1234);
    bus.hi_we = 1'b1; bus.wdata = 32'h0000_ABCD;
    @(negedge clk);
    bus.hi_we = 1'b0;
    chk("mthi idle", bus.HI, 32'h0000_ABCD);
    $display("mtlo/mthi HI=%h LO=%h", bus.HI, bus.LO);

    // MTLO while busy is ignored
    issue(2'b01, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    bus.lo_we = 1'b1; bus.wdata = 32'h0000_DEAD;
    @(negedge clk);
    bus.lo_we = 1'b0;
    chk("mtlo busy", bus.LO, 32'h0000_1234);
    finish_op("multu3x5", 28, 32'd0, 32'd15);

    // start+flush at cycle 10 of CALC
    issue(2'b00, 32'd5, 32'd5);
    repeat (10) @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b01; bus.A = 32'd9; bus.B = 32'd9;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush busy", {31'b0, bus.busy}, 32'd0);
    chk("flush HI", bus.HI, 32'd0);
    chk("flush LO", bus.LO, 32'd15);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    chk("flush no done", {31'b0, saw_done}, 32'd0);
    $display("flush    HI=%h LO=%h", bus.HI, bus.LO);

    // MTHI together with start: write lands, result overwrites later
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.A = 32'd100; bus.B = 32'd7;
    bus.hi_we = 1'b1; bus.wdata = 32'h0000_5555;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    chk("mthi+start HI", bus.HI, 32'h0000_5555);
    finish_op("divu100/7", 33, 32'd2, 32'd14);

    run_op("mult",     2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult7*-6", 2'b00, 32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6);
    run_op("div",      2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div7/-2",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    run_op("divu/0",   2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF);
    run_op("div-5/0",  2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("divovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);

    // Reset mid-CALC
    issue(2'b01, 32'd12345, 32'd678);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst mid busy", {31'b0, bus.busy}, 32'd0);
    chk("rst mid HI", bus.HI, 32'd0);
    chk("rst mid LO", bus.LO, 32'd0);
    $display("rst-mid  HI=%h LO=%h busy=%b", bus.HI, bus.LO, bus.busy);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post rst busy", {31'b0, bus.busy}, 32'd0);
    run_op("multu2", 2'b01, 32'd12345, 32'd678, 32'd0, 32'd8369910);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
